// File: rtl/sos_multich_delay_estimator_pkg.sv
// Shared types and helpers for the multi-channel speed-of-sound delay estimator.
// Holds the controller state encoding and the sample magnitude helper.
package sos_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    ANALYZE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int ABS_W = 32;

  // Sign-extended input is wide enough that -2^(SAMPLE_W-1) never wraps.
  function automatic logic [ABS_W-1:0] abs_sample(input logic signed [ABS_W-1:0] s);
    return s[ABS_W-1] ? $unsigned(-s) : $unsigned(s);
  endfunction

endpackage

// File: rtl/sos_multich_delay_estimator_if.sv
// Bus between the delay estimator and its neighbours: impulse generator
// handshake, mic front-end samples and the per-channel result.
interface sos_multich_delay_estimator_if #(
  parameter int NUM_CH   = 2,
  parameter int SAMPLE_W = 16,
  parameter int DELAY_W  = 8,
  parameter int RC_W     = 2
);
  logic                         step_in;
  logic                         trigger_in;
  logic [NUM_CH*SAMPLE_W-1:0]   mic_in;
  logic                         impulse_req_out;
  logic                         impulse_ack_in;
  logic [NUM_CH*DELAY_W-1:0]    delay_out;
  logic [NUM_CH-1:0]            ch_found_out;
  logic                         delay_valid_out;
  logic                         timeout_out;
  logic                         busy_out;
  logic [RC_W-1:0]              retry_count_out;

  modport master (
    output step_in, trigger_in, mic_in, impulse_ack_in,
    input  impulse_req_out, delay_out, ch_found_out, delay_valid_out,
           timeout_out, busy_out, retry_count_out
  );

  modport slave (
    input  step_in, trigger_in, mic_in, impulse_ack_in,
    output impulse_req_out, delay_out, ch_found_out, delay_valid_out,
           timeout_out, busy_out, retry_count_out
  );
endinterface

// File: rtl/sos_multich_delay_estimator_window_energy.sv
// Per-channel windowed-energy onset detector: accumulates |sample| per window,
// keeps two windows of history and latches the first qualifying onset.
module sos_window_energy
  import sos_pkg::*;
#(
  parameter int SAMPLE_W    = 16,
  parameter int WINDOW_SIZE = 32,
  parameter int DELAY_W     = 8,
  parameter int RATIO_SHIFT = 1,
  parameter int MIN_ENERGY  = 16
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       i_step,
  input  logic                       i_win_end,
  input  logic                       i_clr,
  input  logic [DELAY_W-1:0]         i_win_idx,
  input  logic signed [SAMPLE_W-1:0] i_sample,
  output logic                       o_found,
  output logic                       o_hit,
  output logic [DELAY_W-1:0]         o_delay
);

  localparam int LOG2_WS = $clog2(WINDOW_SIZE);
  localparam int SUM_W   = SAMPLE_W + LOG2_WS;

  logic [SUM_W-1:0]   r_acc;
  logic [SUM_W-1:0]   r_p;
  logic [SUM_W-1:0]   r_pp;
  logic               r_found;
  logic [DELAY_W-1:0] r_delay;

  logic [SUM_W-1:0]   w_cur;
  logic [SUM_W:0]     w_thr;
  logic               w_hit;

  // Magnitude never exceeds 2^(SAMPLE_W-1), so truncation to SUM_W is lossless.
  assign w_cur = r_acc + SUM_W'(abs_sample(ABS_W'(i_sample)));
  assign w_thr = {1'b0, r_pp} + {1'b0, (r_pp >> RATIO_SHIFT)};

  assign w_hit = i_step && i_win_end && !r_found
              && (i_win_idx >= DELAY_W'(2))
              && (w_cur > r_p)
              && ({1'b0, w_cur} > w_thr)
              && (w_cur >= SUM_W'(MIN_ENERGY));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_acc   <= '0;
      r_p     <= '0;
      r_pp    <= '0;
      r_found <= 1'b0;
      r_delay <= '0;
    end else if (i_clr) begin
      r_acc   <= '0;
      r_p     <= '0;
      r_pp    <= '0;
      r_found <= 1'b0;
      r_delay <= '0;
    end else if (i_step && !r_found) begin
      if (i_win_end) begin
        r_pp  <= r_p;
        r_p   <= w_cur;
        r_acc <= '0;
        if (w_hit) begin
          r_found <= 1'b1;
          r_delay <= DELAY_W'(i_win_idx << LOG2_WS);
        end
      end else begin
        r_acc <= w_cur;
      end
    end
  end

  assign o_found = r_found;
  assign o_hit   = w_hit;
  assign o_delay = r_delay;

endmodule

// File: rtl/sos_multich_delay_estimator.sv
// Multi-channel speed-of-sound delay estimator: requests an impulse, runs one
// onset detector per mic channel and retries or times out if a channel is silent.
//
// state   | meaning
// IDLE    | waiting for trigger, results held
// REQ     | impulse requested, waiting for ack
// ANALYZE | counting samples, detectors running
// DONE    | one-cycle result publication
module sos_multich_delay_estimator
  import sos_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int SAMPLE_W    = 16,
  parameter int WINDOW_SIZE = 32,
  parameter int MAX_DELAY   = 255,
  parameter int DELAY_W     = $clog2(MAX_DELAY+1),
  parameter int MAX_RETRIES = 3,
  parameter int RC_W        = $clog2(MAX_RETRIES+1),
  parameter int RATIO_SHIFT = 1,
  parameter int MIN_ENERGY  = 16
) (
  input  logic clk_in,
  input  logic rst_n_in,
  sos_multich_delay_estimator_if.slave bus
);

  localparam int LOG2_WS = $clog2(WINDOW_SIZE);

  state_t             r_state;
  logic [DELAY_W-1:0] r_idx;
  logic [RC_W-1:0]    r_retry;
  logic               r_req;
  logic               r_valid;
  logic               r_timeout;
  logic               r_busy;

  wire  [NUM_CH-1:0]         w_found;
  wire  [NUM_CH-1:0]         w_hit;
  wire  [NUM_CH*DELAY_W-1:0] w_delay_bus;

  logic               w_step;
  logic               w_win_end;
  logic [DELAY_W-1:0] w_win_idx;
  logic               w_all;
  logic               w_last;
  logic               w_can_retry;
  logic               w_clr;

  assign w_step      = bus.step_in && (r_state == ANALYZE);
  assign w_win_end   = &r_idx[LOG2_WS-1:0];
  assign w_win_idx   = r_idx >> LOG2_WS;
  assign w_all       = &(w_found | w_hit);
  assign w_last      = (r_idx == DELAY_W'(MAX_DELAY-1));
  assign w_can_retry = (r_retry < RC_W'(MAX_RETRIES));

  // Detector state is wiped on a new trigger, on each impulse ack and on a retry.
  assign w_clr = ((r_state == IDLE) && bus.trigger_in)
              || ((r_state == REQ) && bus.impulse_ack_in)
              || (w_step && !w_all && w_last && w_can_retry);

  genvar k;
  generate
    for (k = 0; k < NUM_CH; k++) begin : g_ch
      sos_window_energy #(
        .SAMPLE_W    (SAMPLE_W),
        .WINDOW_SIZE (WINDOW_SIZE),
        .DELAY_W     (DELAY_W),
        .RATIO_SHIFT (RATIO_SHIFT),
        .MIN_ENERGY  (MIN_ENERGY)
      ) u_win (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .i_step    (w_step),
        .i_win_end (w_win_end),
        .i_clr     (w_clr),
        .i_win_idx (w_win_idx),
        .i_sample  (bus.mic_in[k*SAMPLE_W +: SAMPLE_W]),
        .o_found   (w_found[k]),
        .o_hit     (w_hit[k]),
        .o_delay   (w_delay_bus[k*DELAY_W +: DELAY_W])
      );
    end
  endgenerate

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_retry   <= '0;
      r_req     <= 1'b0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.trigger_in) begin
            r_state   <= REQ;
            r_req     <= 1'b1;
            r_busy    <= 1'b1;
            r_timeout <= 1'b0;
            r_retry   <= '0;
          end
        end
        REQ: begin
          if (bus.impulse_ack_in) begin
            r_req   <= 1'b0;
            r_idx   <= '0;
            r_state <= ANALYZE;
          end
        end
        ANALYZE: begin
          if (w_step) begin
            if (w_all) begin
              r_state <= DONE;
            end else if (w_last) begin
              if (w_can_retry) begin
                r_retry <= r_retry + RC_W'(1);
                r_req   <= 1'b1;
                r_state <= REQ;
              end else begin
                r_timeout <= 1'b1;
                r_state   <= DONE;
              end
            end else begin
              r_idx <= r_idx + DELAY_W'(1);
            end
          end
        end
        DONE: begin
          r_valid <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.impulse_req_out = r_req;
  assign bus.delay_out       = w_delay_bus;
  assign bus.ch_found_out    = w_found;
  assign bus.delay_valid_out = r_valid;
  assign bus.timeout_out     = r_timeout;
  assign bus.busy_out        = r_busy;
  assign bus.retry_count_out = r_retry;

endmodule

// File: tb/tb_sos_multich_delay_estimator.sv
// Bench for the delay estimator: directed and randomized measurements checked
// against a window-sum onset model computed per attempt.
module tb_sos_multich_delay_estimator;

  localparam int NUM_CH      = 2;
  localparam int SAMPLE_W    = 16;
  localparam int WINDOW_SIZE = 4;
  localparam int MAX_DELAY   = 32;
  localparam int DELAY_W     = 6;
  localparam int MAX_RETRIES = 1;
  localparam int RC_W        = 1;
  localparam int RATIO_SHIFT = 1;
  localparam int MIN_ENERGY  = 16;
  localparam int NWIN        = MAX_DELAY / WINDOW_SIZE;

  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b0;
  always #5 clk_in = ~clk_in;

  sos_multich_delay_estimator_if #(
    .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .DELAY_W(DELAY_W), .RC_W(RC_W)
  ) bus ();

  sos_multich_delay_estimator #(
    .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .WINDOW_SIZE(WINDOW_SIZE),
    .MAX_DELAY(MAX_DELAY), .DELAY_W(DELAY_W), .MAX_RETRIES(MAX_RETRIES),
    .RC_W(RC_W), .RATIO_SHIFT(RATIO_SHIFT), .MIN_ENERGY(MIN_ENERGY)
  ) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input int exp);
    n_checks++;
    if (obs !== 32'(exp)) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // samples per attempt, channel and sample index
  int smp [MAX_RETRIES+1][NUM_CH][MAX_DELAY];

  int         valid_cnt = 0;
  int         req_cnt   = 0;
  logic       prev_req  = 1'b0;
  logic [31:0] cap_found, cap_delay, cap_to, cap_rc, cap_busy;

  always @(negedge clk_in) begin
    if (bus.delay_valid_out === 1'b1) begin
      valid_cnt++;
      cap_found = 32'(bus.ch_found_out);
      cap_delay = 32'(bus.delay_out);
      cap_to    = 32'(bus.timeout_out);
      cap_rc    = 32'(bus.retry_count_out);
      cap_busy  = 32'(bus.busy_out);
    end
    if (bus.impulse_req_out === 1'b1 && prev_req !== 1'b1) req_cnt++;
    prev_req = bus.impulse_req_out;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // First window index whose energy qualifies as an onset, or -1.
  function automatic int onset_win(input int a, input int ch);
    longint sums [NWIN];
    for (int w = 0; w < NWIN; w++) begin
      sums[w] = 0;
      for (int j = 0; j < WINDOW_SIZE; j++) begin
        int v;
        v = smp[a][ch][w*WINDOW_SIZE + j];
        sums[w] += (v < 0) ? -v : v;
      end
    end
    for (int w = 2; w < NWIN; w++) begin
      longint cur, p, pp;
      cur = sums[w];
      p   = sums[w-1];
      pp  = sums[w-2];
      if (cur > p && cur > pp + pp / (1 << RATIO_SHIFT) && cur >= MIN_ENERGY)
        return w;
    end
    return -1;
  endfunction

  task automatic set_step(input int a, input int ch, input int start, input int amp);
    for (int i = 0; i < MAX_DELAY; i++) smp[a][ch][i] = (i >= start) ? amp : 0;
  endtask

  task automatic fill_random(input int a, input int ch);
    int mode, n, start, amp, sgn, noise;
    mode  = int'($urandom_range(0, 3));
    n     = int'($urandom_range(0, 3));
    start = int'($urandom_range(0, 40));
    amp   = int'($urandom_range(0, 32000));
    sgn   = ($urandom_range(0, 1) == 1) ? -1 : 1;
    for (int i = 0; i < MAX_DELAY; i++) begin
      noise = int'($urandom_range(0, 2*n)) - n;
      if (mode == 3) smp[a][ch][i] = int'($urandom_range(0, 65535)) - 32768;
      else           smp[a][ch][i] = (i < start) ? noise : sgn*amp + noise;
    end
  endtask

  task automatic drive_mic(input int a, input int i);
    bus.mic_in = {SAMPLE_W'(smp[a][1][i]), SAMPLE_W'(smp[a][0][i])};
  endtask

  task automatic run_meas(input string name, input bit hold_trig, input bit junk);
    int ow [NUM_CH];
    int exp_found, exp_to, exp_rc, waits, att;
    int exp_d [NUM_CH];
    bit done, retry, ok;
    exp_rc = 0;
    exp_to = 0;
    for (int a = 0; a <= MAX_RETRIES; a++) begin
      bit all;
      all = 1'b1;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        ow[ch] = onset_win(a, ch);
        if (ow[ch] < 0) all = 1'b0;
      end
      exp_rc = a;
      exp_to = all ? 0 : 1;
      if (all) break;
    end
    exp_found = 0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      exp_d[ch] = (ow[ch] >= 0) ? ow[ch] * WINDOW_SIZE : 0;
      if (ow[ch] >= 0) exp_found |= (1 << ch);
    end

    valid_cnt = 0;
    req_cnt   = 0;
    bus.trigger_in = 1'b1;
    tick(1);
    if (!hold_trig) bus.trigger_in = 1'b0;
    att = 0;
    ok  = 1'b1;
    while (ok) begin
      waits = 0;
      while (bus.impulse_req_out !== 1'b1 && waits < 20) begin
        tick(1);
        waits++;
      end
      if (bus.impulse_req_out !== 1'b1) begin
        chk_eq({name, "_req_wait"}, 32'(bus.impulse_req_out), 1);
        ok = 1'b0;
      end else begin
        if (junk) begin
          bus.mic_in  = {NUM_CH{16'sh7000}};
          bus.step_in = 1'b1;
          tick(1);
          bus.step_in = 1'b0;
        end
        tick(3);
        bus.impulse_ack_in = 1'b1;
        tick(1);
        bus.impulse_ack_in = 1'b0;
        done  = 1'b0;
        retry = 1'b0;
        for (int i = 0; i < MAX_DELAY && !done && !retry; i++) begin
          drive_mic(att, i);
          bus.step_in = 1'b1;
          tick(1);
          bus.step_in = 1'b0;
          if (junk && i == 1) bus.impulse_ack_in = 1'b1;
          if (hold_trig && i == 2) bus.trigger_in = 1'b0;
          tick(1);
          bus.impulse_ack_in = 1'b0;
          tick(1);
          if (bus.busy_out === 1'b0) done = 1'b1;
          else if (bus.impulse_req_out === 1'b1) retry = 1'b1;
        end
        if (done) ok = 1'b0;
        else if (!retry) begin
          chk_eq({name, "_analyze_end"}, 0, 1);
          ok = 1'b0;
        end else begin
          att++;
          if (att > MAX_RETRIES) begin
            chk_eq({name, "_attempts"}, 32'(att), MAX_RETRIES);
            ok = 1'b0;
          end
        end
      end
    end
    bus.trigger_in = 1'b0;
    tick(3);
    chk_eq({name, "_valid_pulses"}, 32'(valid_cnt), 1);
    chk_eq({name, "_found"},   cap_found, exp_found);
    chk_eq({name, "_delay0"},  32'(cap_delay[DELAY_W-1:0]), exp_d[0]);
    chk_eq({name, "_delay1"},  32'(cap_delay[2*DELAY_W-1:DELAY_W]), exp_d[1]);
    chk_eq({name, "_timeout"}, cap_to, exp_to);
    chk_eq({name, "_retries"}, cap_rc, exp_rc);
    chk_eq({name, "_impulses"}, 32'(req_cnt), exp_rc + 1);
    chk_eq({name, "_busy_at_valid"}, cap_busy, 0);
    chk_eq({name, "_found_held"}, 32'(bus.ch_found_out), exp_found);
  endtask

  task automatic check_all_zero(input string name);
    chk_eq({name, "_busy"},    32'(bus.busy_out), 0);
    chk_eq({name, "_req"},     32'(bus.impulse_req_out), 0);
    chk_eq({name, "_valid"},   32'(bus.delay_valid_out), 0);
    chk_eq({name, "_found"},   32'(bus.ch_found_out), 0);
    chk_eq({name, "_delay"},   32'(bus.delay_out), 0);
    chk_eq({name, "_timeout"}, 32'(bus.timeout_out), 0);
    chk_eq({name, "_retries"}, 32'(bus.retry_count_out), 0);
  endtask

  initial begin
    bus.step_in        = 1'b0;
    bus.trigger_in     = 1'b0;
    bus.impulse_ack_in = 1'b0;
    bus.mic_in         = '0;
    tick(3);
    check_all_zero("reset");
    rst_n_in = 1'b1;
    tick(2);

    // Two clean onsets
    for (int a = 0; a <= MAX_RETRIES; a++) begin
      set_step(a, 0, 8, 100);
      set_step(a, 1, 12, -200);
    end
    run_meas("two_onsets", 1'b0, 1'b0);

    // Ratio rule: window 2 below 1.5x pp, window 3 above
    for (int a = 0; a <= MAX_RETRIES; a++) begin
      for (int i = 0; i < MAX_DELAY; i++)
        smp[a][0][i] = (i < 8) ? 10 : (i < 12) ? 14 : 16;
      set_step(a, 1, 16, 1000);
    end
    run_meas("ratio", 1'b0, 1'b0);

    // Retry then timeout with one silent channel
    for (int a = 0; a <= MAX_RETRIES; a++) begin
      set_step(a, 0, 8, 100);
      set_step(a, 1, 0, 0);
    end
    run_meas("timeout", 1'b0, 1'b0);

    // Full-scale negative samples
    for (int a = 0; a <= MAX_RETRIES; a++) begin
      set_step(a, 0, 8, -32768);
      set_step(a, 1, 12, -32768);
    end
    run_meas("full_scale", 1'b0, 1'b0);

    // Protocol: stray ack in IDLE, held trigger, stray step in REQ and ack in ANALYZE
    bus.impulse_ack_in = 1'b1;
    tick(1);
    bus.impulse_ack_in = 1'b0;
    tick(2);
    chk_eq("idle_ack_busy", 32'(bus.busy_out), 0);
    chk_eq("idle_ack_req",  32'(bus.impulse_req_out), 0);
    for (int a = 0; a <= MAX_RETRIES; a++) begin
      set_step(a, 0, 9, 500);
      set_step(a, 1, 13, -700);
    end
    run_meas("protocol", 1'b1, 1'b1);

    // Asynchronous reset in the middle of ANALYZE
    set_step(0, 0, 8, 100);
    set_step(0, 1, 0, 0);
    valid_cnt = 0;
    bus.trigger_in = 1'b1;
    tick(1);
    bus.trigger_in = 1'b0;
    tick(2);
    bus.impulse_ack_in = 1'b1;
    tick(1);
    bus.impulse_ack_in = 1'b0;
    for (int i = 0; i < 14; i++) begin
      drive_mic(0, i);
      bus.step_in = 1'b1;
      tick(1);
      bus.step_in = 1'b0;
      tick(1);
    end
    chk_eq("mid_busy_before", 32'(bus.busy_out), 1);
    chk_eq("mid_found_before", 32'(bus.ch_found_out), 1);
    @(negedge clk_in);
    #2 rst_n_in = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk_in);
    rst_n_in = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.step_in = 1'b1;
      bus.impulse_ack_in = (i % 5 == 0);
      tick(1);
      bus.step_in = 1'b0;
      bus.impulse_ack_in = 1'b0;
      tick(1);
    end
    chk_eq("post_reset_valid", 32'(valid_cnt), 0);
    chk_eq("post_reset_busy",  32'(bus.busy_out), 0);
    chk_eq("post_reset_req",   32'(bus.impulse_req_out), 0);

    // Randomized measurements
    for (int t = 0; t < 12; t++) begin
      for (int a = 0; a <= MAX_RETRIES; a++)
        for (int ch = 0; ch < NUM_CH; ch++) fill_random(a, ch);
      run_meas($sformatf("rand%0d", t), 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
